// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (c) and the loader (l).
// Each access runs IDLE -> ACCESS (-> WAIT for reads); saturating per-port grant counters.
module dmem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          CLK,
    input  logic          start,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [15:0]   c_count,
    output logic [15:0]   l_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t        state, state_next;
    logic          sel;
    logic          last;
    logic          pick;
    logic          pick_valid;
    logic [2:0]    wait_cnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // sel/last: 0 = core, 1 = loader; on a tie the port that did not win last time goes
    assign pick_valid = c_req | l_req;
    assign pick       = c_req ? (l_req ? ~last : 1'b0) : 1'b1;

    assign sel_we    = sel ? l_we    : c_we;
    assign sel_addr  = sel ? l_addr  : c_addr;
    assign sel_wdata = sel ? l_wdata : c_wdata;

    assign busy    = (state != IDLE);
    assign c_rdata = c_rvalid ? mem_rdata : '0;
    assign l_rdata = l_rvalid ? mem_rdata : '0;

    always_ff @(posedge CLK) begin
        if (start) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            wait_cnt <= '0;
            c_count  <= '0;
            l_count  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel  <= pick;
                        last <= pick;
                    end
                end
                ACCESS: begin
                    if (!sel_we) begin
                        wait_cnt <= WAIT_INIT;
                    end
                    if (!sel && c_count != 16'hFFFF) begin
                        c_count <= c_count + 16'd1;
                    end
                    if (sel && l_count != 16'hFFFF) begin
                        l_count <= l_count + 16'd1;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pending start suppresses strobes so nothing is issued in the cycle being reset
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        c_rvalid   = 1'b0;
        l_rvalid   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en     = 1'b1;
                mem_we     = sel_we;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
                c_gnt      = ~sel;
                l_gnt      = sel;
                state_next = sel_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    c_rvalid   = ~sel;
                    l_rvalid   = sel;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (start) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            c_gnt     = 1'b0;
            l_gnt     = 1'b0;
            c_rvalid  = 1'b0;
            l_rvalid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3, sharing stimulus.
// Expected read data and grant order go through scoreboard queues checked as the DUT responds.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } rd_t;

    logic        CLK;
    logic        start;
    logic        c_req, c_we, l_req, l_we;
    logic [7:0]  c_addr, l_addr;
    logic [15:0] c_wdata, l_wdata;

    logic        c_gnt_a, c_rvalid_a, l_gnt_a, l_rvalid_a, mem_en_a, mem_we_a, busy_a;
    logic [15:0] c_rdata_a, l_rdata_a, mem_wdata_a, mem_rdata_a, c_count_a, l_count_a;
    logic [7:0]  mem_addr_a;
    logic        c_gnt_b, c_rvalid_b, l_gnt_b, l_rvalid_b, mem_en_b, mem_we_b, busy_b;
    logic [15:0] c_rdata_b, l_rdata_b, mem_wdata_b, mem_rdata_b, c_count_b, l_count_b;
    logic [7:0]  mem_addr_b;

    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];

    rd_t exp_q[$];
    bit  gnt_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    dmem_arbiter #(.AW(8), .DW(16), .MEM_LAT(1)) dut_a (
        .CLK(CLK), .start(start),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_a), .c_rvalid(c_rvalid_a), .c_rdata(c_rdata_a),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_a), .l_rvalid(l_rvalid_a), .l_rdata(l_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .c_count(c_count_a), .l_count(l_count_a)
    );

    dmem_arbiter #(.AW(8), .DW(16), .MEM_LAT(3)) dut_b (
        .CLK(CLK), .start(start),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_b), .c_rvalid(c_rvalid_b), .c_rdata(c_rdata_b),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_b), .l_rvalid(l_rvalid_b), .l_rdata(l_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .c_count(c_count_b), .l_count(l_count_b)
    );

    function automatic logic [15:0] pat(input logic [7:0] addr);
        return (addr == 8'h20) ? 16'h1234 : {addr ^ 8'hA5, addr};
    endfunction

    // Memory models: read data appears MEM_LAT cycles after the strobe, junk otherwise
    always @(posedge CLK) begin
        pipe_a    <= (mem_en_a && !mem_we_a) ? pat(mem_addr_a) : 16'hDEAD;
        pipe_b[0] <= (mem_en_b && !mem_we_b) ? pat(mem_addr_b) : 16'hDEAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rdata_a = pipe_a;
    assign mem_rdata_b = pipe_b[2];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        cyc();
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared += 6;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_busy: got a=%b b=%b, expected 0", busy_a, busy_b);
        end
        if (c_count_a !== 16'h0 || l_count_a !== 16'h0) begin
            mismatched++; $display("[TB] FAIL reset_count_a: got %h/%h, expected 0", c_count_a, l_count_a);
        end
        if (c_count_b !== 16'h0 || l_count_b !== 16'h0) begin
            mismatched++; $display("[TB] FAIL reset_count_b: got %h/%h, expected 0", c_count_b, l_count_b);
        end
        if (mem_en_a !== 1'b0 || mem_en_b !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_mem_en: got a=%b b=%b, expected 0", mem_en_a, mem_en_b);
        end
        if ({c_gnt_a, l_gnt_a, c_gnt_b, l_gnt_b} !== 4'b0) begin
            mismatched++; $display("[TB] FAIL reset_gnt: got %b, expected 0000", {c_gnt_a, l_gnt_a, c_gnt_b, l_gnt_b});
        end
        if (c_rdata_a !== 16'h0 || l_rdata_b !== 16'h0) begin
            mismatched++; $display("[TB] FAIL reset_rdata: got %h/%h, expected 0", c_rdata_a, l_rdata_b);
        end
    endtask

    task automatic test_core_write();
        do_reset();
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h10; c_wdata = 16'hBEEF;
        cyc();
        compared += 3;
        if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || c_gnt_a !== 1'b1) begin
            mismatched++; $display("[TB] FAIL write_strobes: got en=%b we=%b gnt=%b, expected 111", mem_en_a, mem_we_a, c_gnt_a);
        end
        if (mem_addr_a !== 8'h10 || mem_wdata_a !== 16'hBEEF) begin
            mismatched++; $display("[TB] FAIL write_bus_a: got %h/%h, expected 10/beef", mem_addr_a, mem_wdata_a);
        end
        if (mem_we_b !== 1'b1 || mem_addr_b !== 8'h10 || mem_wdata_b !== 16'hBEEF) begin
            mismatched++; $display("[TB] FAIL write_bus_b: got we=%b %h/%h, expected 1 10/beef", mem_we_b, mem_addr_b, mem_wdata_b);
        end
        c_req = 1'b0;
        cyc();
        compared += 2;
        if (c_count_a !== 16'd1) begin
            mismatched++; $display("[TB] FAIL write_count: got %0d, expected 1", c_count_a);
        end
        if (busy_a !== 1'b0) begin
            mismatched++; $display("[TB] FAIL write_busy: got %b, expected 0", busy_a);
        end
    endtask

    task automatic test_loader_read();
        int  gnt_cycle    = -1;
        int  rvalid_cycle = -1;
        bit  c_rv_seen    = 0;
        rd_t e;
        do_reset();
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'h20;
        exp_q.push_back('{port: 1'b1, data: pat(8'h20)});
        for (int cycle = 2; cycle < 10; cycle++) begin
            cyc();
            if (c_rvalid_a) c_rv_seen = 1;
            if (l_gnt_a) begin
                gnt_cycle = cycle;
                l_req     = 1'b0;
            end
            if (l_rvalid_a) begin
                rvalid_cycle = cycle;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL lread_data: got unexpected rvalid with %h, expected none", l_rdata_a);
                end else begin
                    e = exp_q.pop_front();
                    if (l_rdata_a !== e.data || e.port !== 1'b1) begin
                        mismatched++; $display("[TB] FAIL lread_data: got %h, expected %h", l_rdata_a, e.data);
                    end
                end
            end
        end
        compared += 4;
        if (gnt_cycle != 2) begin
            mismatched++; $display("[TB] FAIL lread_gnt_cycle: got %0d, expected 2", gnt_cycle);
        end
        if (rvalid_cycle != 3) begin
            mismatched++; $display("[TB] FAIL lread_rvalid_cycle: got %0d, expected 3", rvalid_cycle);
        end
        if (c_rv_seen) begin
            mismatched++; $display("[TB] FAIL lread_c_rvalid: got 1, expected 0");
        end
        if (exp_q.size() != 0) begin
            mismatched++; $display("[TB] FAIL lread_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int  seen = 0;
        bit  e;
        do_reset();
        for (int i = 0; i < 8; i++) gnt_q.push_back(i[0]);
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h30; c_wdata = 16'h1111;
        l_req = 1'b1; l_we = 1'b1; l_addr = 8'h31; l_wdata = 16'h2222;
        for (int cycle = 0; cycle < 40 && seen < 8; cycle++) begin
            cyc();
            if (c_gnt_a || l_gnt_a) begin
                seen++;
                compared++;
                e = gnt_q.pop_front();
                if (c_gnt_a === l_gnt_a || l_gnt_a !== e) begin
                    mismatched++; $display("[TB] FAIL rr_order[%0d]: got c=%b l=%b, expected loader=%b", seen, c_gnt_a, l_gnt_a, e);
                end
            end
        end
        c_req = 1'b0; l_req = 1'b0;
        cyc();
        compared += 2;
        if (seen != 8) begin
            mismatched++; $display("[TB] FAIL rr_timeout: got %0d grants, expected 8", seen);
            gnt_q.delete();
        end
        if (c_count_a !== 16'd4 || l_count_a !== 16'd4) begin
            mismatched++; $display("[TB] FAIL rr_counts: got %0d/%0d, expected 4/4", c_count_a, l_count_a);
        end
    endtask

    task automatic test_read_latency();
        int  gnt_cycle    = -1;
        int  rvalid_cycle = -1;
        int  busy_n       = 0;
        int  en_n         = 0;
        rd_t e;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h44;
        exp_q.push_back('{port: 1'b0, data: pat(8'h44)});
        for (int cycle = 2; cycle < 14; cycle++) begin
            cyc();
            if (busy_b) busy_n++;
            if (mem_en_b) en_n++;
            if (c_gnt_b) begin
                gnt_cycle = cycle;
                c_req     = 1'b0;
            end
            if (c_rvalid_b) begin
                rvalid_cycle = cycle;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL lat3_data: got unexpected rvalid with %h, expected none", c_rdata_b);
                end else begin
                    e = exp_q.pop_front();
                    if (c_rdata_b !== e.data || e.port !== 1'b0) begin
                        mismatched++; $display("[TB] FAIL lat3_data: got %h, expected %h", c_rdata_b, e.data);
                    end
                end
            end
        end
        compared += 4;
        if (gnt_cycle < 0 || rvalid_cycle - gnt_cycle != 3) begin
            mismatched++; $display("[TB] FAIL lat3_latency: got gnt=%0d rvalid=%0d, expected distance 3", gnt_cycle, rvalid_cycle);
        end
        if (busy_n != 4) begin
            mismatched++; $display("[TB] FAIL lat3_busy: got %0d cycles, expected 4", busy_n);
        end
        if (en_n != 1) begin
            mismatched++; $display("[TB] FAIL lat3_mem_en: got %0d cycles, expected 1", en_n);
        end
        if (exp_q.size() != 0) begin
            mismatched++; $display("[TB] FAIL lat3_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_in_wait();
        bit rv_seen  = 0;
        bit got_gnt  = 0;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h44;
        cyc();
        compared++;
        if (c_gnt_b !== 1'b1) begin
            mismatched++; $display("[TB] FAIL rst_wait_gnt: got %b, expected 1", c_gnt_b);
        end
        c_req = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        compared += 2;
        if (busy_b !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_wait_busy: got %b, expected 0", busy_b);
        end
        if (c_count_b !== 16'h0 || l_count_b !== 16'h0) begin
            mismatched++; $display("[TB] FAIL rst_wait_counts: got %h/%h, expected 0", c_count_b, l_count_b);
        end
        for (int i = 0; i < 5; i++) begin
            if (c_rvalid_b || l_rvalid_b) rv_seen = 1;
            cyc();
        end
        compared++;
        if (rv_seen) begin
            mismatched++; $display("[TB] FAIL rst_wait_rvalid: got 1, expected 0");
        end
        c_req = 1'b1; c_we = 1'b1; l_req = 1'b1; l_we = 1'b1;
        for (int i = 0; i < 6 && !got_gnt; i++) begin
            cyc();
            if (c_gnt_b || l_gnt_b) begin
                got_gnt = 1;
                compared++;
                if (c_gnt_b !== 1'b1 || l_gnt_b !== 1'b0) begin
                    mismatched++; $display("[TB] FAIL rst_wait_tie: got c=%b l=%b, expected c=1 l=0", c_gnt_b, l_gnt_b);
                end
            end
        end
        c_req = 1'b0; l_req = 1'b0;
        if (!got_gnt) begin
            compared++; mismatched++;
            $display("[TB] FAIL rst_wait_tie_timeout: got no grant, expected core grant");
        end
        cyc();
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt = 16'hFFFE;
        bit          got;
        do_reset();
        force dut_a.c_count = 16'hFFFE;
        cyc();
        release dut_a.c_count;
        for (int n = 0; n < 3; n++) begin
            got   = 0;
            c_req = 1'b1; c_we = 1'b1; c_addr = 8'h50 + 8'(n); c_wdata = 16'h0F0F;
            for (int i = 0; i < 6 && !got; i++) begin
                cyc();
                if (c_gnt_a) got = 1;
            end
            c_req = 1'b0;
            cyc();
            if (got && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            compared++;
            if (!got || c_count_a !== exp_cnt) begin
                mismatched++; $display("[TB] FAIL sat_count[%0d]: got %h (gnt=%b), expected %h", n, c_count_a, got, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_core_write();
        test_loader_read();
        test_back_to_back();
        test_read_latency();
        test_reset_in_wait();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor core (port c) and the program/data loader (port l).
- Arbitration is round-robin. The block sequences each access through a small FSM and times read-data return against the fixed memory latency.
- Keeps saturating per-port access counters for bench and debug visibility, in the same style as the instruction counter.

Parameters:
- AW, 8, memory address width.
- DW, 16, memory data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- start  in  1  reset, synchronous, active-high.
- c_req  in  1  core access request; held until c_gnt.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_gnt  out  1  one-cycle pulse: core access issued to memory.
- c_rvalid  out  1  one-cycle pulse: c_rdata valid.
- c_rdata  out  DW  core read data.
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: loader port, same widths and meaning as the core port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  FSM not in IDLE.
- c_count  out  16  granted core accesses, saturates at 16'hFFFF.
- l_count  out  16  granted loader accesses, saturates at 16'hFFFF.

Behaviour:
- Interface: one clock, CLK. Reset start is synchronous and active-high.
- Reset (start=1 at a rising edge) forces:
  - state=IDLE and last=1, so the core wins the first tie;
  - all outputs 0, both counts 0, wait counter 0.
  - This holds even mid-access: an in-flight read is discarded and no rvalid is issued.
- State IDLE:
  - If neither request is present, stay in IDLE.
  - If exactly one port requests, select that port.
  - If both request, select the port != last.
  - On a selection, latch sel, set last<=sel, go to ACCESS.
- State ACCESS (one cycle):
  - Drive mem_en=1, plus mem_we/addr/wdata from the selected port's live inputs.
  - Pulse gnt of the selected port.
  - Increment that port's count unless it is already 16'hFFFF.
  - If write, next state is IDLE.
  - If read, load wait_cnt=MEM_LAT-1 and go to WAIT.
- State WAIT:
  - mem_en=0.
  - While wait_cnt!=0, decrement it.
  - When wait_cnt==0 (the cycle that is MEM_LAT cycles after ACCESS), assert rvalid of the selected port for exactly that cycle and go to IDLE.
- Read data path:
  - c_rdata and l_rdata are driven from mem_rdata combinationally when their rvalid is high, and are 0 otherwise.
- Throughput:
  - Write occupies 2 cycles (IDLE+ACCESS).
  - Read occupies MEM_LAT+2 cycles.
  - There is no pipelining; at most one access is outstanding.
- Outside ACCESS, mem_en, mem_we, mem_addr and mem_wdata are all 0.
- busy = (state != IDLE).
- A request arriving during ACCESS or WAIT waits; it is arbitrated in the next IDLE cycle.
- A requester must hold req and its operands stable until gnt.
  - Deasserting req after selection but before gnt does not cancel the access.
- A port whose req stays high after gnt is treated as a new request in the next IDLE cycle.
  - Round-robin then alternates under continuous contention, so neither port starves.
- A requester may not deassert start-independent state; start always wins over every other event in the same cycle.

Test Plan:
- Reset, then core writes: c_req=1, c_we=1, c_addr=8'h10, c_wdata=16'hBEEF.
  - Expect mem_en=mem_we=1, mem_addr=8'h10, mem_wdata=16'hBEEF and c_gnt=1, all in cycle 2.
  - Expect c_count=1 and busy=0 in cycle 3.
- MEM_LAT=1, loader reads 8'h20, memory model returns 16'h1234.
  - Expect l_gnt in cycle 2 and l_rvalid=1 with l_rdata=16'h1234 in cycle 3.
  - Expect c_rvalid=0 throughout.
- Both ports hold write requests continuously for 8 accesses after reset.
  - Expect grant order c,l,c,l,c,l,c,l.
  - Expect c_count=l_count=4.
- MEM_LAT=3, core read.
  - Expect c_rvalid exactly 3 cycles after c_gnt.
  - Expect busy high for 4 cycles and mem_en high for exactly 1 cycle.
- Assert start during WAIT of a MEM_LAT=3 read.
  - Expect the next cycle to be IDLE with no rvalid, counts 0 and busy=0.
  - Expect a following tie to grant core first.
- Force c_count to 16'hFFFE, then perform 3 core writes.
  - Expect c_count to saturate at 16'hFFFF.
